// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling phrase sequencer.
package scroll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        SCROLL = 2'd2,
        WRAP   = 2'd3
    } state_e;

    // Speed switch encodings: step period is the base divide shifted right by speed.
    localparam logic [1:0] SPEED_X1 = 2'b00;
    localparam logic [1:0] SPEED_X2 = 2'b01;
    localparam logic [1:0] SPEED_X4 = 2'b10;
    localparam logic [1:0] SPEED_X8 = 2'b11;

    localparam int unsigned DEF_TICK_DIV        = 25_000_000;
    localparam int unsigned DEF_DIV_WIDTH       = 25;
    localparam int unsigned DEF_PHRASE_LEN      = 16;
    localparam int unsigned DEF_LOOPS_TO_FINISH = 10;
    localparam int unsigned LOOP_CNT_W          = 4;

    // Terminal divider value for a speed setting; the period never drops below one cycle.
    function automatic int unsigned step_term(input int unsigned tick_div,
                                              input logic [1:0]  speed);
        int unsigned period;
        period = tick_div;
        case (speed)
            SPEED_X1: period = tick_div;
            SPEED_X2: period = tick_div >> 1;
            SPEED_X4: period = tick_div >> 2;
            SPEED_X8: period = tick_div >> 3;
            default:  period = tick_div;
        endcase
        if (period == 0) begin
            period = 1;
        end
        return period - 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running step divider: counts enabled cycles and pulses tick once the
// count reaches term. The >= compare means a shrinking term fires at once
// instead of letting the counter run past it and wrap.
module tick_divider #(
    parameter int unsigned DIV_WIDTH = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] term,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    assign tick = en && (cnt_q >= term);

    // Next count: clear has priority, then restart on tick, else count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scroll_sequencer.sv
// Scroll sequencer: steps a character index through the phrase at a switch
// selected rate, pulses led_enable at the start of each phrase loop and
// counts completed loops up to a saturating finish value.
module scroll_sequencer
    import scroll_pkg::*;
#(
    parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
    parameter int unsigned DIV_WIDTH       = DEF_DIV_WIDTH,
    parameter int unsigned PHRASE_LEN      = DEF_PHRASE_LEN,
    parameter int unsigned LOOPS_TO_FINISH = DEF_LOOPS_TO_FINISH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic [1:0]                    speed,
    output logic                          scroll_tick,
    output logic [$clog2(PHRASE_LEN)-1:0] char_index,
    output logic                          led_enable,
    output logic [LOOP_CNT_W-1:0]         loop_count,
    output logic                          finished
);

    localparam int unsigned IDX_W = $clog2(PHRASE_LEN);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(PHRASE_LEN - 1);
    localparam logic [LOOP_CNT_W-1:0] LOOP_MAX = LOOP_CNT_W'(LOOPS_TO_FINISH);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [LOOP_CNT_W-1:0]   loops_q, loops_d;
    logic                    led_q, led_d;
    logic                    fin_q, fin_d;
    logic                    div_en;
    logic                    div_clr;
    logic                    tick;
    logic [DIV_WIDTH-1:0]    term;

    assign term = DIV_WIDTH'(step_term(TICK_DIV, speed));

    tick_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (div_en),
        .clr   (div_clr),
        .term  (term),
        .tick  (tick)
    );

    // Next state, index and loop count; index/count change on entry to a
    // state so that START/WRAP show their values alongside led_enable.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        loops_d = loops_q;
        div_en  = 1'b0;
        div_clr = 1'b0;
        case (state_q)
            IDLE: begin
                div_clr = 1'b1;
                idx_d   = '0;
                if (run) begin
                    state_d = START;
                end
            end
            START: begin
                div_clr = 1'b1;
                state_d = SCROLL;
            end
            SCROLL: begin
                div_en = run;
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        loops_d = (loops_q >= LOOP_MAX) ? loops_q
                                                        : loops_q + LOOP_CNT_W'(1);
                        state_d = WRAP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            WRAP: begin
                div_clr = 1'b1;
                state_d = SCROLL;
            end
            default: begin
                div_clr = 1'b1;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
        led_d = (state_d == START) || (state_d == WRAP);
        fin_d = (loops_d == LOOP_MAX);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            loops_q <= '0;
            led_q   <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            loops_q <= loops_d;
            led_q   <= led_d;
            fin_q   <= fin_d;
        end
    end

    assign scroll_tick = tick;
    assign char_index  = idx_q;
    assign led_enable  = led_q;
    assign loop_count  = loops_q;
    assign finished    = fin_q;

endmodule
